stamp_counter_dds: RTL and testbench

STAMP_COUNTER_DDS -- requirements
Module: stamp_counter_dds

---
 rtl/stamp_pkg.sv | 15 +
 rtl/stamp_rate_servo.sv | 122 ++++++++++++
 rtl/stamp_counter_dds.sv | 111 +++++++++++
 tb/tb_stamp_counter_dds.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stamp_pkg.sv
// Shared definitions for the PPS-disciplined timestamp counter: servo state encoding and the
// default period/timeout constants.
package stamp_pkg;

    typedef enum logic [1:0] {
        StFree     = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2,
        StHoldover = 2'd3
    } lock_state_e;

    localparam int unsigned NomCyclesDefault  = 32'd160000000;
    localparam int unsigned PpsTimeoutDefault = 32'h1312d000;

endpackage

// File: rtl/stamp_rate_servo.sv
// PPS period measurement and rate servo: trims the fractional rate so the measured period
// converges on NOM_CYCLES, with lock qualification and holdover on PPS loss.
module stamp_rate_servo
    import stamp_pkg::*;
#(
    parameter int unsigned DDS_WIDTH  = 32,
    parameter int unsigned NOM_CYCLES = NomCyclesDefault,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOCK_TOL   = 16,
    parameter int unsigned GAIN_SHIFT = 4
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    input  logic                 pps_valid,
    input  logic                 wd_zero,
    input  logic                 correction_mode,
    input  logic [DDS_WIDTH-1:0] rate_init,
    output logic [1:0]           lock_state,
    output logic [DDS_WIDTH-1:0] dds_rate
);

    localparam int unsigned PW   = 32;
    localparam int unsigned UW   = DDS_WIDTH + PW + GAIN_SHIFT + 2;
    localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [PW:0] Nom    = (PW + 1)'(NOM_CYCLES);
    localparam logic signed [PW:0] TolPos = (PW + 1)'(LOCK_TOL);

    lock_state_e         state_q;
    logic [DDS_WIDTH-1:0] rate_q;
    logic [PW-1:0]       period_q;
    logic [CntW-1:0]     cnt_q;

    logic signed [PW:0]   err;
    logic                 in_tol;
    logic signed [UW-1:0] err_w;
    logic signed [UW-1:0] upd;
    logic [DDS_WIDTH-1:0] rate_upd;

    always_comb begin
        err    = $signed({1'b0, period_q}) - Nom;
        in_tol = (err <= TolPos) && (err >= -TolPos);
        err_w  = {{(UW - PW - 1){err[PW]}}, err};
        upd    = $signed({{(UW - DDS_WIDTH){1'b0}}, rate_q}) - (err_w <<< GAIN_SHIFT);
        // Clamp into [0, all-ones] rather than letting the rate wrap.
        if (upd[UW-1]) begin
            rate_upd = '0;
        end else if (|upd[UW-2:DDS_WIDTH]) begin
            rate_upd = '1;
        end else begin
            rate_upd = upd[DDS_WIDTH-1:0];
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state_q  <= StFree;
            rate_q   <= rate_init;
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (pps_valid) begin
                period_q <= PW'(1);
            end else if (!(&period_q)) begin
                period_q <= period_q + 1'b1;
            end

            if (!correction_mode) begin
                state_q <= StFree;
                rate_q  <= rate_init;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StFree: begin
                        rate_q <= rate_init;
                        if (pps_valid) begin
                            state_q <= StAcquire;
                            cnt_q   <= '0;
                        end
                    end
                    StAcquire: begin
                        if (pps_valid) begin
                            rate_q <= rate_upd;
                            if (!in_tol) begin
                                cnt_q <= '0;
                            end else if (cnt_q == CntW'(LOCK_COUNT - 1)) begin
                                state_q <= StLocked;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else if (wd_zero) begin
                            state_q <= StFree;
                            rate_q  <= rate_init;
                            cnt_q   <= '0;
                        end
                    end
                    StLocked: begin
                        if (pps_valid) begin
                            rate_q <= rate_upd;
                            if (!in_tol) begin
                                state_q <= StAcquire;
                            end
                        end else if (wd_zero) begin
                            state_q <= StHoldover;
                        end
                    end
                    StHoldover: begin
                        if (pps_valid) begin
                            state_q <= StAcquire;
                            cnt_q   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign lock_state = state_q;
    assign dds_rate   = rate_q;

endmodule

// File: rtl/stamp_counter_dds.sv
// Free-running timestamp counter with a fractional DDS carry, PPS capture, PPS-loss watchdog
// and a rate servo that disciplines the fractional rate to the PPS period.
module stamp_counter_dds
    import stamp_pkg::*;
#(
    parameter int unsigned TIMESTAMP_WIDTH = 64,
    parameter int unsigned DDS_WIDTH       = 32,
    parameter int unsigned TICK_INC        = 28,
    parameter int unsigned NOM_CYCLES      = NomCyclesDefault,
    parameter int unsigned PPS_TIMEOUT     = PpsTimeoutDefault,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned LOCK_TOL        = 16,
    parameter int unsigned GAIN_SHIFT      = 4
) (
    input  logic                       axi_aclk,
    input  logic                       axi_resetn,
    input  logic                       pps_rx,
    input  logic [1:0]                 restart_time,
    input  logic [TIMESTAMP_WIDTH-1:0] ntp_timestamp,
    input  logic                       adjust_valid,
    input  logic [TIMESTAMP_WIDTH-1:0] adjust_offset,
    input  logic                       correction_mode,
    input  logic [DDS_WIDTH-1:0]       rate_init,
    output logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    output logic [TIMESTAMP_WIDTH-1:0] pps_stamp,
    output logic                       pps_stamp_valid,
    output logic                       gps_connected,
    output logic [1:0]                 lock_state,
    output logic [DDS_WIDTH-1:0]       dds_rate
);

    localparam logic [TIMESTAMP_WIDTH-1:0] TickInc    = TIMESTAMP_WIDTH'(TICK_INC);
    localparam logic [31:0]                PpsTimeout = 32'(PPS_TIMEOUT);

    logic [2:0]                 pps_sync_q;
    logic [31:0]                wd_q;
    logic [DDS_WIDTH-1:0]       acc_q;
    logic [TIMESTAMP_WIDTH-1:0] stamp_q;
    logic [TIMESTAMP_WIDTH-1:0] pps_stamp_q;
    logic                       pps_stamp_valid_q;

    logic                       pps_valid;
    logic                       wd_zero;
    logic [DDS_WIDTH:0]         acc_sum;
    logic [TIMESTAMP_WIDTH-1:0] stamp_inc;

    always_comb begin
        pps_valid = !pps_sync_q[1] && pps_sync_q[2];
        wd_zero   = (wd_q == '0);
        acc_sum   = {1'b0, acc_q} + {1'b0, dds_rate};
        stamp_inc = stamp_q + TickInc + TIMESTAMP_WIDTH'(acc_sum[DDS_WIDTH]);
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            pps_sync_q        <= '0;
            wd_q              <= '0;
            acc_q             <= '0;
            stamp_q           <= '0;
            pps_stamp_q       <= '0;
            pps_stamp_valid_q <= 1'b0;
        end else begin
            pps_sync_q <= {pps_sync_q[1:0], pps_rx};

            if (pps_valid) begin
                wd_q <= PpsTimeout;
            end else if (!wd_zero) begin
                wd_q <= wd_q - 1'b1;
            end

            pps_stamp_valid_q <= pps_valid;
            if (pps_valid) begin
                pps_stamp_q <= stamp_q;
            end

            // A load holds the accumulator so the fractional phase survives a time set.
            if (restart_time[0]) begin
                stamp_q <= ntp_timestamp;
            end else if (restart_time[1]) begin
                stamp_q <= '0;
                acc_q   <= '0;
            end else begin
                acc_q   <= acc_sum[DDS_WIDTH-1:0];
                stamp_q <= adjust_valid ? stamp_inc + adjust_offset : stamp_inc;
            end
        end
    end

    stamp_rate_servo #(
        .DDS_WIDTH  (DDS_WIDTH),
        .NOM_CYCLES (NOM_CYCLES),
        .LOCK_COUNT (LOCK_COUNT),
        .LOCK_TOL   (LOCK_TOL),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_servo (
        .axi_aclk        (axi_aclk),
        .axi_resetn      (axi_resetn),
        .pps_valid       (pps_valid),
        .wd_zero         (wd_zero),
        .correction_mode (correction_mode),
        .rate_init       (rate_init),
        .lock_state      (lock_state),
        .dds_rate        (dds_rate)
    );

    assign stamp_counter   = stamp_q;
    assign pps_stamp       = pps_stamp_q;
    assign pps_stamp_valid = pps_stamp_valid_q;
    assign gps_connected   = !wd_zero;

endmodule

// File: tb/tb_stamp_counter_dds.sv
// Self-checking bench for stamp_counter_dds: timestamp arithmetic, PPS capture via a
// scoreboard, and the rate servo against a small behavioural model.
module tb_stamp_counter_dds;

    localparam int TW   = 64;
    localparam int DW   = 32;
    localparam int TICK = 28;
    localparam int NOM  = 200;
    localparam int TO   = 300;
    localparam int LCNT = 4;
    localparam int TOL  = 16;
    localparam int GS   = 4;

    logic          axi_aclk = 1'b0;
    logic          axi_resetn;
    logic          pps_rx;
    logic [1:0]    restart_time;
    logic [TW-1:0] ntp_timestamp;
    logic          adjust_valid;
    logic [TW-1:0] adjust_offset;
    logic          correction_mode;
    logic [DW-1:0] rate_init;
    logic [TW-1:0] stamp_counter;
    logic [TW-1:0] pps_stamp;
    logic          pps_stamp_valid;
    logic          gps_connected;
    logic [1:0]    lock_state;
    logic [DW-1:0] dds_rate;

    stamp_counter_dds #(
        .TIMESTAMP_WIDTH (TW),
        .DDS_WIDTH       (DW),
        .TICK_INC        (TICK),
        .NOM_CYCLES      (NOM),
        .PPS_TIMEOUT     (TO),
        .LOCK_COUNT      (LCNT),
        .LOCK_TOL        (TOL),
        .GAIN_SHIFT      (GS)
    ) dut (
        .axi_aclk        (axi_aclk),
        .axi_resetn      (axi_resetn),
        .pps_rx          (pps_rx),
        .restart_time    (restart_time),
        .ntp_timestamp   (ntp_timestamp),
        .adjust_valid    (adjust_valid),
        .adjust_offset   (adjust_offset),
        .correction_mode (correction_mode),
        .rate_init       (rate_init),
        .stamp_counter   (stamp_counter),
        .pps_stamp       (pps_stamp),
        .pps_stamp_valid (pps_stamp_valid),
        .gps_connected   (gps_connected),
        .lock_state      (lock_state),
        .dds_rate        (dds_rate)
    );

    always #5 axi_aclk = ~axi_aclk;

    int edge_cnt = 0;
    always @(posedge axi_aclk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int            when;
        logic [TW-1:0] stamp;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t sb_it;
    bit       sb_on = 1'b1;

    // Servo model state.
    int            m_state;
    int            m_cnt;
    logic [DW-1:0] m_rate;

    logic [TW-1:0] exp_stamp;
    logic [DW-1:0] m_acc;
    logic [DW:0]   m_sum;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    // Falling edges of consecutive calls are exactly n cycles apart; 10 cycles of margin
    // after each fall let the servo update settle before the caller checks.
    task automatic pps_period(input int n);
        pps_rx = 1'b1;
        step(n - 10);
        pps_rx = 1'b0;
        step(10);
    endtask

    task automatic model_pps(input int per);
        longint er;
        longint nr;
        bit     tol;
        er  = longint'(per) - longint'(NOM);
        tol = (er <= TOL) && (er >= -TOL);
        nr  = longint'(m_rate) - er * (64'sd1 << GS);
        if (nr < 0) nr = 0;
        if (nr > 64'sh0000_0000_FFFF_FFFF) nr = 64'sh0000_0000_FFFF_FFFF;
        case (m_state)
            0: begin
                m_state = 1;
                m_cnt   = 0;
            end
            1: begin
                m_rate = nr[DW-1:0];
                if (tol) begin
                    m_cnt++;
                    if (m_cnt == LCNT) begin
                        m_state = 2;
                        m_cnt   = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            2: begin
                m_rate = nr[DW-1:0];
                if (!tol) m_state = 1;
            end
            default: begin
                m_state = 1;
                m_cnt   = 0;
            end
        endcase
    endtask

    task automatic pulse(input int n);
        pps_period(n);
        model_pps(n);
        check_eq("servo_state", 64'(lock_state), 64'(m_state));
        check_eq("servo_rate", 64'(dds_rate), 64'(m_rate));
    endtask

    task automatic model_free(input logic [DW-1:0] r);
        m_state = 0;
        m_cnt   = 0;
        m_rate  = r;
    endtask

    // PPS capture monitor: every strobe must match the next scoreboard entry.
    initial begin
        forever begin
            @(posedge axi_aclk);
            #1;
            if (sb_on && pps_stamp_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("pps_extra_strobe", 64'(pps_stamp_valid), 64'd0);
                end else begin
                    sb_it = sb_q.pop_front();
                    check_eq("pps_when", 64'(edge_cnt), 64'(sb_it.when));
                    check_eq("pps_stamp", pps_stamp, sb_it.stamp);
                end
            end
        end
    end

    initial begin
        axi_resetn      = 1'b0;
        pps_rx          = 1'b0;
        restart_time    = 2'b00;
        ntp_timestamp   = '0;
        adjust_valid    = 1'b0;
        adjust_offset   = '0;
        correction_mode = 1'b0;
        rate_init       = 32'h1234_5678;
        model_free(32'h0);
        #1;
        step(3);
        check_eq("rst_stamp", stamp_counter, 64'd0);
        check_eq("rst_pps_stamp", pps_stamp, 64'd0);
        check_eq("rst_pps_valid", 64'(pps_stamp_valid), 64'd0);
        check_eq("rst_gps", 64'(gps_connected), 64'd0);
        check_eq("rst_state", 64'(lock_state), 64'd0);
        check_eq("rst_rate", 64'(dds_rate), 64'h1234_5678);
        rate_init = '0;
        step(1);
        axi_resetn = 1'b1;

        // Load then free-run at zero fractional rate.
        restart_time  = 2'b01;
        ntp_timestamp = 64'h100;
        step(1);
        restart_time = 2'b00;
        check_eq("load_0", stamp_counter, 64'h100);
        step(1);
        check_eq("load_1", stamp_counter, 64'h11C);
        step(1);
        check_eq("load_2", stamp_counter, 64'h138);

        // Wrap, load-over-zero priority, signed adjust, zero-over-adjust priority.
        exp_stamp     = 64'hFFFF_FFFF_FFFF_FFF6;
        ntp_timestamp = exp_stamp;
        restart_time  = 2'b01;
        step(1);
        restart_time = 2'b00;
        check_eq("wrap_load", stamp_counter, exp_stamp);
        step(1);
        check_eq("wrap_next", stamp_counter, 64'd18);
        ntp_timestamp = 64'hABCD;
        restart_time  = 2'b11;
        step(1);
        restart_time = 2'b00;
        check_eq("load_beats_zero", stamp_counter, 64'hABCD);
        exp_stamp    = 64'hABCD;
        adjust_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            adjust_offset = (i == 0) ? -64'sd5 : 64'd1000;
            step(1);
            exp_stamp = exp_stamp + 64'(TICK) + adjust_offset;
            check_eq("adjust", stamp_counter, exp_stamp);
        end
        restart_time = 2'b10;
        step(1);
        restart_time = 2'b00;
        adjust_valid = 1'b0;
        check_eq("zero_beats_adjust", stamp_counter, 64'd0);
        step(1);
        check_eq("after_zero", stamp_counter, 64'd28);

        // Half-rate carry: increments alternate 28, 29.
        rate_init    = 32'h8000_0000;
        restart_time = 2'b10;
        step(1);
        restart_time = 2'b00;
        check_eq("half_zero", stamp_counter, 64'd0);
        check_eq("half_rate", 64'(dds_rate), 64'h8000_0000);
        exp_stamp = '0;
        m_acc     = '0;
        for (int i = 1; i <= 1000; i++) begin
            step(1);
            m_sum     = {1'b0, m_acc} + {1'b0, rate_init};
            m_acc     = m_sum[DW-1:0];
            exp_stamp = exp_stamp + 64'(TICK) + 64'(m_sum[DW]);
            if (i <= 4) check_eq("half_step", stamp_counter, exp_stamp);
        end
        check_eq("half_1000", stamp_counter, 64'd28500);

        // PPS capture timing at zero rate.
        rate_init = '0;
        pps_rx    = 1'b1;
        step(4);
        ntp_timestamp = 64'h1000;
        restart_time  = 2'b01;
        step(1);
        restart_time = 2'b00;
        step(3);
        pps_rx = 1'b0;
        sb_q.push_back('{edge_cnt + 3, 64'h1000 + 64'(5 * TICK)});
        step(8);
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        check_eq("gps_after_pps", 64'(gps_connected), 64'd1);

        // Servo: acquire, lock, tolerance edge, relock.
        sb_on           = 1'b0;
        correction_mode = 1'b1;
        rate_init       = 32'h8000_0000;
        model_free(rate_init);
        step(2);
        for (int i = 0; i < 6; i++) pulse(NOM + 8);
        pulse(NOM + TOL);
        pulse(NOM + TOL + 1);
        for (int i = 0; i < 4; i++) pulse(NOM + 8);

        // Loss of PPS while locked: holdover with rate frozen.
        step(TO + 2 - 10);
        check_eq("gps_before_loss", 64'(gps_connected), 64'd1);
        step(1);
        check_eq("gps_lost", 64'(gps_connected), 64'd0);
        step(1);
        m_state = 3;
        check_eq("holdover_state", 64'(lock_state), 64'd3);
        check_eq("holdover_rate", 64'(dds_rate), 64'(m_rate));
        step(20);
        check_eq("holdover_frozen", 64'(dds_rate), 64'(m_rate));
        pulse(NOM + 8);
        pulse(NOM + 8);

        // Loss of PPS while acquiring: back to free-run at rate_init.
        step(TO + 4 - 10);
        model_free(rate_init);
        check_eq("acq_loss_state", 64'(lock_state), 64'd0);
        check_eq("acq_loss_rate", 64'(dds_rate), 64'(m_rate));

        // Low saturation, then correction_mode=0 override.
        rate_init = 32'd100;
        model_free(rate_init);
        step(2);
        pulse(NOM + 8);
        pulse(NOM + 8);
        rate_init       = 32'h7000_0000;
        correction_mode = 1'b0;
        step(1);
        check_eq("override_state", 64'(lock_state), 64'd0);
        check_eq("override_rate", 64'(dds_rate), 64'h7000_0000);

        // High saturation.
        rate_init       = 32'hFFFF_FFC0;
        correction_mode = 1'b1;
        model_free(rate_init);
        step(2);
        pulse(NOM + 8);
        pulse(NOM - 8);

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
